// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction ROM address, captures the fetched word into IF/ID.
// Latency: the word at imem_addr_o appears on if_id_* one cycle later; a redirect costs one bubble.
// Backpressure: stall_i holds PC and IF/ID; redirect_i overrides stall_i; no input-to-output comb path.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Sequential PC increment; wraps naturally at 2^32.
  assign pc_plus4    = pc + 32'd4;
  // The ROM is combinational-read, so the address is simply the current PC.
  assign imem_addr_o = pc;

  // PC, IF/ID register, misalign pulse and fetch counter; priority is reset > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      if_id_pc_o    <= 32'd0;
      if_id_pc4_o   <= 32'd0;
      if_id_instr_o <= NOP_INSTR;
      if_id_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      fetch_count_o <= 32'd0;
    end else if (redirect_i) begin
      // Target is word-aligned by dropping the low bits; a nonzero low pair is flagged for one cycle.
      pc            <= {redirect_pc_i[31:2], 2'b00};
      if_id_pc_o    <= 32'd0;
      if_id_pc4_o   <= 32'd0;
      if_id_instr_o <= NOP_INSTR;
      if_id_valid_o <= 1'b0;
      misalign_o    <= |redirect_pc_i[1:0];
    end else if (stall_i) begin
      // Hold everything; only the misalign pulse is cleared so it never lasts more than one cycle.
      misalign_o    <= 1'b0;
    end else begin
      pc            <= pc_plus4;
      if_id_pc_o    <= pc;
      if_id_pc4_o   <= pc_plus4;
      if_id_instr_o <= imem_rdata_i;
      if_id_valid_o <= 1'b1;
      misalign_o    <= 1'b0;
      fetch_count_o <= fetch_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        misalign_o;
  logic [31:0] fetch_count_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .if_id_pc_o   (if_id_pc_o),
    .if_id_pc4_o  (if_id_pc4_o),
    .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o),
    .misalign_o   (misalign_o),
    .fetch_count_o(fetch_count_o)
  );

  // Memory model: each word encodes its own address.
  assign imem_rdata_i = 32'h1000_0000 | imem_addr_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: after each rising edge, compare DUT state against the next expected entry.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".imem_addr"}, imem_addr_o,          e.addr);
      chk({e.tag, ".pc"},        if_id_pc_o,           e.pc);
      chk({e.tag, ".pc4"},       if_id_pc4_o,          e.pc4);
      chk({e.tag, ".instr"},     if_id_instr_o,        e.instr);
      chk({e.tag, ".valid"},     {31'd0, if_id_valid_o}, {31'd0, e.valid});
      chk({e.tag, ".misalign"},  {31'd0, misalign_o},  {31'd0, e.mis});
      chk({e.tag, ".count"},     fetch_count_o,        e.cnt);
    end
  end

  // Drive one cycle of inputs and queue the state expected after the following edge.
  task automatic vec(input string tag, input logic rst, input logic stl, input logic red,
                     input logic [31:0] rpc, input logic [31:0] addr, input logic [31:0] pc,
                     input logic [31:0] pc4, input logic [31:0] instr, input logic valid,
                     input logic mis, input logic [31:0] cnt);
    exp_t e;
    @(negedge clk);
    rst_n         = rst;
    stall_i       = stl;
    redirect_i    = red;
    redirect_pc_i = rpc;
    e.addr = addr; e.pc = pc; e.pc4 = pc4; e.instr = instr;
    e.valid = valid; e.mis = mis; e.cnt = cnt; e.tag = tag;
    exp_q.push_back(e);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;

    //   tag        rst stl red rpc            addr           pc             pc4            instr          v  m  cnt
    vec("reset0",   0,  0,  0,  32'h0,         32'h0,         32'h0,         32'h0,         NOP,           0, 0, 0);
    vec("reset1",   0,  1,  1,  32'h44,        32'h0,         32'h0,         32'h0,         NOP,           0, 0, 0);
    // Scenario 1: three advances
    vec("adv1",     1,  0,  0,  32'h0,         32'h4,         32'h0,         32'h4,         32'h1000_0000, 1, 0, 1);
    vec("adv2",     1,  0,  0,  32'h0,         32'h8,         32'h4,         32'h8,         32'h1000_0004, 1, 0, 2);
    vec("adv3",     1,  0,  0,  32'h0,         32'hC,         32'h8,         32'hC,         32'h1000_0008, 1, 0, 3);
    // Scenario 2: two-cycle stall then advance
    vec("stall1",   1,  1,  0,  32'h0,         32'hC,         32'h8,         32'hC,         32'h1000_0008, 1, 0, 3);
    vec("stall2",   1,  1,  0,  32'h0,         32'hC,         32'h8,         32'hC,         32'h1000_0008, 1, 0, 3);
    vec("unstall",  1,  0,  0,  32'h0,         32'h10,        32'hC,         32'h10,        32'h1000_000C, 1, 0, 4);
    // Scenario 3: redirect to 0x40
    vec("redir40",  1,  0,  1,  32'h40,        32'h40,        32'h0,         32'h0,         NOP,           0, 0, 4);
    vec("adv40",    1,  0,  0,  32'h0,         32'h44,        32'h40,        32'h44,        32'h1000_0040, 1, 0, 5);
    // Scenario 4: redirect wins over stall
    vec("redstl80", 1,  1,  1,  32'h80,        32'h80,        32'h0,         32'h0,         NOP,           0, 0, 5);
    vec("adv80",    1,  0,  0,  32'h0,         32'h84,        32'h80,        32'h84,        32'h1000_0080, 1, 0, 6);
    // Scenario 5: misaligned redirect pulses once
    vec("redir42",  1,  0,  1,  32'h42,        32'h40,        32'h0,         32'h0,         NOP,           0, 1, 6);
    vec("adv42",    1,  0,  0,  32'h0,         32'h44,        32'h40,        32'h44,        32'h1000_0040, 1, 0, 7);
    vec("redir43",  1,  0,  1,  32'h43,        32'h40,        32'h0,         32'h0,         NOP,           0, 1, 7);
    vec("stallmis", 1,  1,  0,  32'h0,         32'h40,        32'h0,         32'h0,         NOP,           0, 0, 7);
    // Scenario 6: wrap at top of address space, then reset during stall
    vec("redirtop", 1,  0,  1,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,         NOP,           0, 0, 7);
    vec("advwrap",  1,  0,  0,  32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 1, 0, 8);
    vec("rststall", 0,  1,  1,  32'h42,        32'h0,         32'h0,         32'h0,         NOP,           0, 0, 0);
    vec("advpost",  1,  0,  0,  32'h0,         32'h4,         32'h0,         32'h4,         32'h1000_0000, 1, 0, 1);

    @(negedge clk);
    stall_i = 1'b1;
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage in-order RV32 pipeline. Owns the program counter and drives the combinational-read instruction ROM address. Captures the returned word into the IF/ID pipeline register. Handles hazard stalls and EX-resolved branch/jump redirects, inserting a NOP bubble on each redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on redirect/reset.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
imem_addr_o  output  32  byte address to instruction memory; combinational copy of PC.
imem_rdata_i  input  32  instruction word from memory; valid same cycle as imem_addr_o.
stall_i  input  1  hazard hold from ID/hazard unit.
redirect_i  input  1  taken branch/jump from EX.
redirect_pc_i  input  32  target address, qualified by redirect_i.
if_id_pc_o  output  32  PC of the instruction in IF/ID.
if_id_pc4_o  output  32  if_id_pc_o + 4, used for JAL/JALR link.
if_id_instr_o  output  32  instruction in IF/ID.
if_id_valid_o  output  1  1 = real instruction; 0 = bubble.
misalign_o  output  1  one-cycle pulse: last redirect target had nonzero bits [1:0].
fetch_count_o  output  32  count of instructions committed into IF/ID (valid=1 captures).

Behaviour:
- Reset (rst_n=0 at edge) sets: pc=RESET_PC, if_id_instr_o=NOP_INSTR, if_id_valid_o=0, if_id_pc_o=0, if_id_pc4_o=0, misalign_o=0, fetch_count_o=0. Reset mid-operation discards all state; redirect_i and stall_i are ignored that cycle.
- imem_addr_o = pc, combinationally, in every cycle including reset.
- Per-edge priority when rst_n=1: redirect > stall > advance.
- Redirect (redirect_i=1, regardless of stall_i):
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - IF/ID <= bubble: instr=NOP_INSTR, valid=0, pc=0, pc4=0.
  - misalign_o <= |redirect_pc_i[1:0].
  - fetch_count_o holds.
- Stall (redirect_i=0, stall_i=1): pc, IF/ID, fetch_count_o hold; misalign_o <= 0.
- Advance (both 0):
  - IF/ID <= {pc, pc+4, imem_rdata_i, valid=1}.
  - pc <= pc+4.
  - fetch_count_o <= fetch_count_o+1.
  - misalign_o <= 0.
- Latency: word at address A appears on if_id_* at the edge after imem_addr_o=A. Fetch-to-IF/ID latency is 1 cycle.
- Redirect penalty: one bubble cycle in IF/ID. The EX-side flush of ID is handled outside this block.
- Arithmetic is mod 2^32:
  - pc 0xFFFF_FFFC advances to 0x0000_0000.
  - if_id_pc4_o wraps the same way.
  - fetch_count_o wraps to 0.
- Out-of-range addresses are passed through unchanged; the memory folds them.
- misalign_o is a single-cycle pulse. It is not sticky and raises no exception.
- No combinational path from stall_i/redirect_i to any output.

Test Plan:
1. Release reset (RESET_PC=0); memory returns 0x1000_0000|addr; 3 advance cycles -> if_id_pc_o 0,4,8; if_id_instr_o 0x1000_0008; valid=1; fetch_count_o=3; before the first edge, valid=0 and instr=0x13.
2. After the scenario 1 state (pc=0xC), hold stall_i=1 for 2 cycles -> if_id_pc_o stays 8, imem_addr_o stays 0xC, count stays 3; deassert -> next edge if_id_pc_o=0xC, count=4.
3. redirect_i=1, redirect_pc_i=0x40 -> next edge: valid=0, instr=0x13, imem_addr_o=0x40, count unchanged; following advance: if_id_pc_o=0x40, if_id_pc4_o=0x44, valid=1.
4. redirect_i=1 and stall_i=1 same cycle, target 0x80 -> redirect wins: pc=0x80, bubble inserted; misalign_o=0.
5. Redirect to 0x42 -> imem_addr_o=0x40, misalign_o=1 for exactly one cycle, then 0.
6. Force pc=0xFFFF_FFFC via redirect, advance -> if_id_pc4_o=0, imem_addr_o=0. Then assert rst_n=0 during a stall -> next edge shows full reset values.
